// File: rtl/ad_lvds_deframer.sv
// AD9361 LVDS receive deframer: aligns to the frame lane, rebuilds 12-bit I/Q
// samples from 6-bit half-words and reports per-channel sample sets.
module ad_lvds_deframer #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rstn,
  input  logic [5:0]       rx_data_p,
  input  logic [5:0]       rx_data_n,
  input  logic             rx_frame_p,
  input  logic             rx_frame_n,
  input  logic             mode_1r,
  input  logic             err_clr,
  output logic             adc_valid,
  output logic [11:0]      adc_data_i0,
  output logic [11:0]      adc_data_q0,
  output logic [11:0]      adc_data_i1,
  output logic [11:0]      adc_data_q1,
  output logic             adc_locked,
  output logic             adc_odd,
  output logic [ERR_W-1:0] adc_err_cnt
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [3:0] LOCK_N    = 4'(LOCK_CNT);

  logic [1:0]       r_state;
  logic [1:0]       r_phase;
  logic             r_p0_f;     // frame bit of previous cycle's W0
  logic [6:0]       r_p1;       // previous cycle's W1 (frame + data)
  logic             r_pp1_f;    // frame bit of W1 two cycles back
  logic             r_mode;
  logic [3:0]       r_good;
  logic [5:0]       r_msb_i;
  logic [5:0]       r_msb_q;
  logic [11:0]      r_hold_i;   // ch0 sample parked until ch1 completes (2R)
  logic [11:0]      r_hold_q;
  logic             r_valid;
  logic [11:0]      r_i0;
  logic [11:0]      r_q0;
  logic [11:0]      r_i1;
  logic [11:0]      r_q1;
  logic             r_odd;
  logic [ERR_W-1:0] r_err;

  logic [6:0] w_w0;
  logic [6:0] w_w1;
  logic       w_mode_chg;
  logic       w_even_edge;
  logic       w_odd_edge;
  logic       w_edge;
  logic       w_odd_sel;
  logic [6:0] w_pair_i;
  logic [6:0] w_pair_q;
  logic       w_exp_f;
  logic       w_pair_ok;
  logic       w_track;
  logic       w_mismatch;
  logic       w_last;
  logic       w_set_done;
  logic       w_emit;
  logic       w_msb_ph;

  assign w_w0       = {rx_frame_p, rx_data_p};
  assign w_w1       = {rx_frame_n, rx_data_n};
  assign w_mode_chg = (mode_1r != r_mode);

  // In 2R the pair ahead of the edge must also be a low-frame pair.
  assign w_even_edge = !r_p1[6] && w_w0[6] && w_w1[6] && (r_mode || !r_p0_f);
  assign w_odd_edge  = !r_p0_f && r_p1[6] && w_w0[6] && (r_mode || !r_pp1_f);
  assign w_edge      = (r_state == ST_SEARCH) && !w_mode_chg && (w_even_edge || w_odd_edge);

  // While searching, the pair choice follows the edge just found (even wins).
  assign w_odd_sel = (r_state == ST_SEARCH) ? !w_even_edge : r_odd;
  assign w_pair_i  = w_odd_sel ? r_p1 : w_w0;
  assign w_pair_q  = w_odd_sel ? w_w0 : w_w1;

  assign w_exp_f    = r_mode ? (r_phase == 2'd0) : !r_phase[1];
  assign w_pair_ok  = (w_pair_i[6] == w_exp_f) && (w_pair_q[6] == w_exp_f);
  assign w_track    = (r_state != ST_SEARCH) && !w_mode_chg;
  assign w_mismatch = w_track && !w_pair_ok;
  assign w_last     = r_mode ? (r_phase == 2'd1) : (r_phase == 2'd3);
  assign w_set_done = w_track && w_pair_ok && w_last;
  assign w_emit     = w_set_done && (r_state == ST_LOCKED);
  assign w_msb_ph   = w_edge || (w_track && w_pair_ok && !r_phase[0]);

  assign adc_valid   = r_valid;
  assign adc_data_i0 = r_i0;
  assign adc_data_q0 = r_q0;
  assign adc_data_i1 = r_i1;
  assign adc_data_q1 = r_q1;
  assign adc_locked  = (r_state == ST_LOCKED);
  assign adc_odd     = r_odd;
  assign adc_err_cnt = r_err;

  // Half-word history and mode tracking.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      r_p0_f  <= 1'b0;
      r_p1    <= '0;
      r_pp1_f <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_p0_f  <= w_w0[6];
      r_p1    <= w_w1;
      r_pp1_f <= r_p1[6];
      r_mode  <= mode_1r;
    end
  end

  // Alignment state, phase counter and lock qualification.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      r_state <= ST_SEARCH;
      r_phase <= 2'd0;
      r_good  <= 4'd0;
      r_odd   <= 1'b0;
    end else if (w_mode_chg) begin
      r_state <= ST_SEARCH;
      r_phase <= 2'd0;
    end else if (r_state == ST_SEARCH) begin
      r_phase <= 2'd0;
      if (w_edge) begin
        r_state <= ST_VERIFY;
        r_phase <= 2'd1;
        r_good  <= 4'd0;
        r_odd   <= !w_even_edge;
      end
    end else if (w_mismatch) begin
      r_state <= ST_SEARCH;
      r_phase <= 2'd0;
    end else begin
      r_phase <= w_last ? 2'd0 : r_phase + 2'd1;
      if ((r_state == ST_VERIFY) && w_set_done) begin
        if (r_good + 4'd1 == LOCK_N) begin
          r_state <= ST_LOCKED;
        end else begin
          r_good <= r_good + 4'd1;
        end
      end
    end
  end

  // Sample assembly: latch high halves, park ch0 in 2R until the set ends.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      r_msb_i  <= '0;
      r_msb_q  <= '0;
      r_hold_i <= '0;
      r_hold_q <= '0;
    end else begin
      if (w_msb_ph) begin
        r_msb_i <= w_pair_i[5:0];
        r_msb_q <= w_pair_q[5:0];
      end
      if (w_track && w_pair_ok && !r_mode && (r_phase == 2'd1)) begin
        r_hold_i <= {r_msb_i, w_pair_i[5:0]};
        r_hold_q <= {r_msb_q, w_pair_q[5:0]};
      end
    end
  end

  // Output register: data only moves together with the valid strobe.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      r_valid <= 1'b0;
      r_i0    <= '0;
      r_q0    <= '0;
      r_i1    <= '0;
      r_q1    <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        if (r_mode) begin
          r_i0 <= {r_msb_i, w_pair_i[5:0]};
          r_q0 <= {r_msb_q, w_pair_q[5:0]};
          r_i1 <= '0;
          r_q1 <= '0;
        end else begin
          r_i0 <= r_hold_i;
          r_q0 <= r_hold_q;
          r_i1 <= {r_msb_i, w_pair_i[5:0]};
          r_q1 <= {r_msb_q, w_pair_q[5:0]};
        end
      end
    end
  end

  // Saturating frame-error counter; a clear beats a same-cycle mismatch.
  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      r_err <= '0;
    end else if (err_clr) begin
      r_err <= '0;
    end else if (w_mismatch && !(&r_err)) begin
      r_err <= r_err + 1'b1;
    end
  end

endmodule

// File: tb/tb_ad_lvds_deframer.sv
// Randomised bench for ad_lvds_deframer: builds half-word streams from
// sample sets and predicts outputs from a set-level lock model.
module tb_ad_lvds_deframer;

  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 4;
  localparam int MAXC     = 128;
  localparam int MAXH     = 2 * MAXC + 4;
  localparam int MAXS     = 64;

  logic             rx_clk = 1'b0;
  logic             rx_rstn = 1'b0;
  logic [5:0]       rx_data_p = '0;
  logic [5:0]       rx_data_n = '0;
  logic             rx_frame_p = 1'b0;
  logic             rx_frame_n = 1'b0;
  logic             mode_1r = 1'b0;
  logic             err_clr = 1'b0;
  logic             adc_valid;
  logic [11:0]      adc_data_i0;
  logic [11:0]      adc_data_q0;
  logic [11:0]      adc_data_i1;
  logic [11:0]      adc_data_q1;
  logic             adc_locked;
  logic             adc_odd;
  logic [ERR_W-1:0] adc_err_cnt;

  always #5 rx_clk = ~rx_clk;

  ad_lvds_deframer #(
    .LOCK_CNT(LOCK_CNT),
    .ERR_W   (ERR_W)
  ) dut (
    .rx_clk     (rx_clk),
    .rx_rstn    (rx_rstn),
    .rx_data_p  (rx_data_p),
    .rx_data_n  (rx_data_n),
    .rx_frame_p (rx_frame_p),
    .rx_frame_n (rx_frame_n),
    .mode_1r    (mode_1r),
    .err_clr    (err_clr),
    .adc_valid  (adc_valid),
    .adc_data_i0(adc_data_i0),
    .adc_data_q0(adc_data_q0),
    .adc_data_i1(adc_data_i1),
    .adc_data_q1(adc_data_q1),
    .adc_locked (adc_locked),
    .adc_odd    (adc_odd),
    .adc_err_cnt(adc_err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus description: samples per set (I0,Q0,I1,Q1), corruption, clears.
  logic [11:0] smp  [MAXS][4];
  bit          corr [MAXS];
  int          cpos [MAXS];
  bit          e_clr[MAXC];

  // Model events per observed cycle.
  logic [6:0]  hw    [MAXH];
  bit          e_acq [MAXC];
  bit          e_lon [MAXC];
  bit          e_loff[MAXC];
  bit          e_mism[MAXC];
  bit          e_val [MAXC];
  logic [11:0] e_dat [MAXC][4];

  task automatic prep(input int nsets, input bit m1r, input int corr_pct, input int clr_pct);
    for (int s = 0; s < MAXS; s++) begin
      for (int k = 0; k < 4; k++) smp[s][k] = 12'($urandom);
      corr[s] = (s < nsets) && ($urandom_range(0, 99) < corr_pct);
      cpos[s] = m1r ? 0 : int'($urandom_range(0, 1));
    end
    for (int c = 0; c < MAXC; c++) e_clr[c] = ($urandom_range(0, 99) < clr_pct);
  endtask

  // end_kind: 0 = stream stops (trailing mismatch), 1 = mode toggle, 2 = reset.
  task automatic run_scn(input bit m1r, input bit odd, input int nsets, input int end_kind,
                         input string name);
    int   pre, pps, hps, ncyc, base, c0, cend, cm, g, tog_c, rst_c;
    bit   hunting, fb;
    int   ch;
    logic m_lk, m_odd, m_val;
    int   m_err;
    logic [11:0] m_dat [4];

    pre = 8 + int'(odd);
    pps = m1r ? 2 : 4;
    hps = 2 * pps;
    ncyc = (pre + (nsets + 1) * hps + 1) / 2 + 4;

    // Build the half-word stream.
    for (int i = 0; i < MAXH; i++) hw[i] = {1'b0, 6'($urandom)};
    for (int s = 0; s < nsets; s++) begin
      base = pre + s * hps;
      for (int k = 0; k < pps; k++) begin
        ch = k / 2;
        fb = m1r ? (k == 0) : (k < 2);
        hw[base + 2*k]     = {fb, (k % 2 == 0) ? smp[s][2*ch][11:6]   : smp[s][2*ch][5:0]};
        hw[base + 2*k + 1] = {fb, (k % 2 == 0) ? smp[s][2*ch+1][11:6] : smp[s][2*ch+1][5:0]};
      end
      if (corr[s]) hw[base + 2*cpos[s] + 1][6] = 1'b0;
    end

    // Set-level model of acquisition, lock and output.
    for (int c = 0; c < MAXC; c++) begin
      e_acq[c] = 0; e_lon[c] = 0; e_loff[c] = 0; e_mism[c] = 0; e_val[c] = 0;
    end
    hunting = 1; g = 0; tog_c = -1; rst_c = -1;
    for (int s = 0; s < nsets; s++) begin
      base = pre + s * hps;
      c0   = (base + 1) / 2;
      cend = (base + hps - 1) / 2;
      if (end_kind != 0 && s == nsets - 1) begin
        if (end_kind == 1) begin
          tog_c = c0;
          e_loff[c0] = 1;
        end else begin
          rst_c = c0;
        end
        hunting = 1;
        break;
      end
      if (corr[s]) begin
        cm = (base + 2*cpos[s] + 1) / 2;
        if (!hunting || cpos[s] > 0) begin
          if (hunting) e_acq[c0] = 1;
          e_mism[cm] = 1;
          e_loff[cm] = 1;
        end
        hunting = 1; g = 0;
      end else if (hunting) begin
        hunting = 0; g = 1; e_acq[c0] = 1;
        if (g == LOCK_CNT) e_lon[cend] = 1;
      end else if (g >= LOCK_CNT) begin
        e_val[cend] = 1;
        for (int k = 0; k < 4; k++) e_dat[cend][k] = (m1r && k >= 2) ? 12'd0 : smp[s][k];
      end else begin
        g++;
        if (g == LOCK_CNT) e_lon[cend] = 1;
      end
    end
    if (end_kind == 0 && !hunting) begin
      c0 = (pre + nsets * hps + 1) / 2;
      e_mism[c0] = 1;
      e_loff[c0] = 1;
    end

    // Reset, then check the reset state.
    rx_rstn = 1'b0; mode_1r = m1r; err_clr = 1'b0;
    rx_data_p = '0; rx_data_n = '0; rx_frame_p = 1'b0; rx_frame_n = 1'b0;
    @(posedge rx_clk); #1;
    check_eq({name, " rst valid"},  32'(adc_valid),   32'd0);
    check_eq({name, " rst locked"}, 32'(adc_locked),  32'd0);
    check_eq({name, " rst odd"},    32'(adc_odd),     32'd0);
    check_eq({name, " rst err"},    32'(adc_err_cnt), 32'd0);
    check_eq({name, " rst data"},
             32'(|{adc_data_i0, adc_data_q0, adc_data_i1, adc_data_q1}), 32'd0);
    @(posedge rx_clk); #1;
    rx_rstn = 1'b1;

    m_lk = 0; m_odd = 0; m_val = 0; m_err = 0;
    for (int k = 0; k < 4; k++) m_dat[k] = '0;

    for (int c = 0; c < ncyc; c++) begin
      rx_data_p  = hw[2*c][5:0];
      rx_frame_p = hw[2*c][6];
      rx_data_n  = hw[2*c+1][5:0];
      rx_frame_n = hw[2*c+1][6];
      mode_1r    = (tog_c >= 0 && c >= tog_c) ? ~m1r : m1r;
      err_clr    = e_clr[c];
      rx_rstn    = !(rst_c >= 0 && c >= rst_c && c < rst_c + 5);
      @(posedge rx_clk); #1;

      if (rst_c >= 0 && c >= rst_c) begin
        m_lk = 0; m_odd = 0; m_val = 0; m_err = 0;
        for (int k = 0; k < 4; k++) m_dat[k] = '0;
      end else begin
        if (e_acq[c]) m_odd = odd;
        if (e_lon[c]) m_lk = 1;
        if (e_loff[c]) m_lk = 0;
        if (e_clr[c]) m_err = 0;
        else if (e_mism[c] && m_err < (1 << ERR_W) - 1) m_err++;
        m_val = e_val[c];
        if (e_val[c]) for (int k = 0; k < 4; k++) m_dat[k] = e_dat[c][k];
      end

      check_eq($sformatf("%s c%0d valid", name, c),  32'(adc_valid),   32'(m_val));
      check_eq($sformatf("%s c%0d locked", name, c), 32'(adc_locked),  32'(m_lk));
      check_eq($sformatf("%s c%0d odd", name, c),    32'(adc_odd),     32'(m_odd));
      check_eq($sformatf("%s c%0d err", name, c),    32'(adc_err_cnt), 32'(m_err));
      check_eq($sformatf("%s c%0d i0", name, c),     32'(adc_data_i0), 32'(m_dat[0]));
      check_eq($sformatf("%s c%0d q0", name, c),     32'(adc_data_q0), 32'(m_dat[1]));
      check_eq($sformatf("%s c%0d i1", name, c),     32'(adc_data_i1), 32'(m_dat[2]));
      check_eq($sformatf("%s c%0d q1", name, c),     32'(adc_data_q1), 32'(m_dat[3]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit rm, ro;

    // 1R even, fixed sample values.
    prep(10, 1'b1, 0, 0);
    for (int s = 0; s < 10; s++) begin
      smp[s][0] = 12'hA5C; smp[s][1] = 12'h3F1;
    end
    run_scn(1'b1, 1'b0, 10, 0, "1r_even");

    // 1R shifted by one half-word.
    prep(10, 1'b1, 0, 0);
    for (int s = 0; s < 10; s++) begin
      smp[s][0] = 12'hA5C; smp[s][1] = 12'h3F1;
    end
    run_scn(1'b1, 1'b1, 10, 0, "1r_odd");

    // 2R even, fixed corner values.
    prep(10, 1'b0, 0, 0);
    for (int s = 0; s < 10; s++) begin
      smp[s][0] = 12'h800; smp[s][1] = 12'h7FF; smp[s][2] = 12'h001; smp[s][3] = 12'hFFF;
    end
    run_scn(1'b0, 1'b0, 10, 0, "2r_even");

    // 2R locked, frame_n dropped on a phase-1 cycle, then relock.
    prep(14, 1'b0, 0, 0);
    corr[6] = 1; cpos[6] = 1;
    run_scn(1'b0, 1'b0, 14, 0, "2r_glitch");

    // Counter saturation, then a clear coincident with a mismatch.
    prep(42, 1'b1, 0, 0);
    for (int s = 0; s < 42; s++) begin
      corr[s] = (s % 2 == 1); cpos[s] = 0;
    end
    e_clr[(8 + 41 * 4 + 1) / 2] = 1;
    run_scn(1'b1, 1'b0, 42, 0, "sat");

    // Mode toggle while locked, both directions.
    prep(8, 1'b1, 0, 0);
    run_scn(1'b1, 1'b0, 8, 1, "tog_1r");
    prep(8, 1'b0, 0, 0);
    run_scn(1'b0, 1'b1, 8, 1, "tog_2r");

    // Reset in the middle of a set.
    prep(8, 1'b0, 0, 0);
    run_scn(1'b0, 1'b1, 8, 2, "rst_mid");

    // Random mode, alignment, corruption and clears.
    for (int i = 0; i < 8; i++) begin
      rm = 1'($urandom);
      ro = 1'($urandom);
      prep(20, rm, 15, 5);
      run_scn(rm, ro, int'($urandom_range(6, 20)), 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
